aes_iter_core: RTL
==================

// Module: aes_iter_core
// PURPOSE
//  Parametrised iterative AES encryption core, successor to the fixed AES-128 top.
//  Supports 128- or 256-bit keys with on-the-fly key expansion (4 words/cycle).
//  Uses valid/ready handshakes on input and output instead of a free-running pc/finish.
//  Executes one full round per clock. Sits between the block-mode wrapper and the text stream.
// PARAMETERS
//  KEY_WIDTH   128  key size in bits; legal values 128 or 256 (anything else: elaboration error)
//  NR          KEY_WIDTH/32+6  round count, derived (10 or 14); not overridable
//  NK          KEY_WIDTH/32    key words, derived (4 or 8); not overridable
// PORTS
//  clk_i        in   1          clock, rising edge
//  rst_i        in   1          synchronous active-high reset
//  in_valid_i   in   1          plaintext/key offered
//  in_ready_o   out  1          core can accept a block
//  plaintext_i  in   128        plaintext, byte 0 = bits [127:120]
//  key_i        in   KEY_WIDTH  cipher key, word 0 = top 32 bits
//  out_valid_o  out  1          ciphertext_o valid
//  out_ready_i  in   1          downstream accepts ciphertext
//  ciphertext_o out  128        ciphertext, same byte order as plaintext_i
//  round_o      out  4          current round index (0 when idle)
// BEHAVIOUR
//  Reset (rst_i=1 at a clock edge): state IDLE; in_ready_o=1, out_valid_o=0,
//   ciphertext_o=0, round_o=0; state, key-window and rcon registers cleared.
//   Takes effect from any state, including mid-RUN; the in-flight block is discarded.
//  FSM: IDLE -> RUN on accept; RUN -> DONE when round_o==NR; DONE -> IDLE on out_ready_i.
//   DONE -> RUN directly if out_ready_i and an accept occur in the same cycle.
//  in_ready_o = (state==IDLE) | (state==DONE & out_ready_i) (combinational).
//  Accept = in_valid_i & in_ready_o at a rising edge. On accept:
//   data <= plaintext_i ^ key_i[KEY_WIDTH-1 -: 128] (round-key 0).
//   Key window <= key_i (NK words); rcon <= 8'h01; round_o <= 1.
//   key_i and plaintext_i are don't-care after the accept edge.
//  RUN edge, round r (1..NR): data <= AddRoundKey(MixColumns(ShiftRows(SubBytes(data))), RK[r]).
//   MixColumns is bypassed when r==NR.
//  Round keys: RK[r] = expanded words 4r..4r+3.
//   NK=4: 4 new words per cycle; w[i] for i%4==0 uses RotWord+SubWord+rcon.
//   NK=8: RK[1] = key lower 128 bits, taken from the window with no new words generated in round 1.
//    Thereafter 4 new words per cycle, alternating two block types:
//     i%8==0 block: RotWord+SubWord+rcon.
//     i%8==4 block: SubWord only, no rcon.
//   rcon advances by xtime (01,02,..,80,1b,36) after each use only.
//  Last round edge (r==NR): ciphertext_o <= result; out_valid_o <= 1; round_o <= 0.
//  Latency: out_valid_o rises NR cycles after the accept edge (10 for 128, 14 for 256).
//  DONE: ciphertext_o and out_valid_o held stable until out_ready_i=1.
//   out_valid_o falls on that edge unless a new accept also occurs.
//  out_ready_i is ignored outside DONE. in_valid_i is ignored during RUN (in_ready_o=0).
//  S-box: team's combinational aes_sbox, 16 instances for data plus 4 for key words.
//  No combinational path from in_valid_i to out_valid_o.
// TESTING
//  1 KW=128, pt 00112233445566778899aabbccddeeff, key 000102..0f
//    -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 10 cycles after accept.
//  2 KW=128, pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c
//    -> ct 3925841d02dc09fbdc118597196a0b32.
//  3 KW=256, pt 00112233445566778899aabbccddeeff, key 000102..1f
//    -> ct 8ea2b7ca516745bfeafc49904b496089, out_valid 14 cycles after accept.
//  4 Hold out_ready_i=0 for 5 cycles in DONE -> ciphertext and out_valid stable, in_ready_o=0.
//    Then out_ready_i=1 with in_valid_i=1 -> next block accepted on the same edge, round_o=1.
//  5 Assert rst_i at round 5 -> next cycle IDLE, out_valid_o=0, round_o=0, in_ready_o=1.
//    A fresh test-1 block then gives the correct ct.
//  6 Change key_i/plaintext_i every cycle during RUN -> result is unaffected (test-1 ct).

Source files
------------

// File: rtl/aes_iter_core.sv
// Iterative AES encryption core: one full round per clock, 128- or 256-bit key.
// Latency: ciphertext valid NR cycles after the accepting edge (10 or 14).
// Backpressure: result held in DONE until out_ready_i; a new block may be accepted on that same edge.

// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv;

  // Inverse computed as a^254 (squares a^2..a^128 multiplied together); 0 maps to 0.
  always_comb begin
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a_i;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    inv = acc;
  end

  assign s_o = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;

endmodule

module aes_iter_core #(
  parameter int KEY_WIDTH = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [127:0]         plaintext_i,
  input  logic [KEY_WIDTH-1:0] key_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [127:0]         ciphertext_o,
  output logic [3:0]           round_o
);

  localparam int NK = KEY_WIDTH / 32;
  localparam int NR = NK + 6;

  if (KEY_WIDTH != 128 && KEY_WIDTH != 256) begin : g_bad_key_width
    $error("aes_iter_core: KEY_WIDTH must be 128 or 256");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [127:0]         data_q, data_d;
  logic [127:0]         ct_q, ct_d;
  logic [KEY_WIDTH-1:0] kwin_q, kwin_d;
  logic [7:0]           rcon_q, rcon_d;
  logic [3:0]           round_q, round_d;

  logic                 accept;
  logic                 last_round;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // ---------------------------------------------------------------------------
  // Key schedule. The window holds the most recent NK expanded words, word 0 in
  // the top bits. Each RUN cycle derives the next four words from it.
  // ---------------------------------------------------------------------------
  logic                 use_rot;
  logic [31:0]          kw_last, kw_sub_in, kw_sub_out, kw_f;
  logic [31:0]          n0, n1, n2, n3;
  logic [127:0]         new_blk;
  logic [127:0]         rk_w;
  logic [KEY_WIDTH-1:0] kwin_nxt;

  // With an 8-word key the blocks alternate: even rounds start at i%8==0
  // (RotWord+rcon), odd rounds at i%8==4 (SubWord only). rcon steps only when used.
  assign use_rot   = (NK == 4) || !round_q[0];
  assign kw_last   = kwin_q[31:0];
  assign kw_sub_in = use_rot ? {kw_last[23:0], kw_last[31:24]} : kw_last;

  for (genvar k = 0; k < 4; k++) begin : g_sbox_key
    aes_sbox u_sbox (.a_i(kw_sub_in[31-8*k -: 8]), .s_o(kw_sub_out[31-8*k -: 8]));
  end

  assign kw_f    = kw_sub_out ^ (use_rot ? {rcon_q, 24'h000000} : 32'h0);
  assign n0      = kwin_q[KEY_WIDTH-1   -: 32] ^ kw_f;
  assign n1      = kwin_q[KEY_WIDTH-33  -: 32] ^ n0;
  assign n2      = kwin_q[KEY_WIDTH-65  -: 32] ^ n1;
  assign n3      = kwin_q[KEY_WIDTH-97  -: 32] ^ n2;
  assign new_blk = {n0, n1, n2, n3};

  if (NK == 4) begin : g_ks128
    assign rk_w     = new_blk;
    assign kwin_nxt = new_blk;
  end else begin : g_ks256
    // Round 1 uses the lower half of the original key; nothing new is generated.
    assign rk_w     = (round_q == 4'd1) ? kwin_q[127:0] : new_blk;
    assign kwin_nxt = (round_q == 4'd1) ? kwin_q : {kwin_q[127:0], new_blk};
  end

  // ---------------------------------------------------------------------------
  // Round datapath: SubBytes, ShiftRows, MixColumns (skipped on the last round),
  // AddRoundKey. Byte b of the state lives at bits [127-8b -: 8], column-major.
  // ---------------------------------------------------------------------------
  logic [7:0]   sb_b [16];
  logic [127:0] sr_pk;
  logic [127:0] mc_pk;
  logic [127:0] round_res;

  for (genvar b = 0; b < 16; b++) begin : g_sbox_dat
    aes_sbox u_sbox (.a_i(data_q[127-8*b -: 8]), .s_o(sb_b[b]));
  end

  for (genvar c = 0; c < 4; c++) begin : g_shift_col
    for (genvar r = 0; r < 4; r++) begin : g_shift_row
      assign sr_pk[127-8*(4*c+r) -: 8] = sb_b[4*((c+r)%4)+r];
    end
  end

  // MixColumns on each 32-bit column of the shifted state.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    mc_pk = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = sr_pk[127-32*c    -: 8];
      a1 = sr_pk[127-32*c-8  -: 8];
      a2 = sr_pk[127-32*c-16 -: 8];
      a3 = sr_pk[127-32*c-24 -: 8];
      mc_pk[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                               xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
  end

  assign last_round = (round_q == 4'(NR));
  assign round_res  = (last_round ? sr_pk : mc_pk) ^ rk_w;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: a DONE handshake with a simultaneous accept goes straight back to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (last_round) state_d = S_DONE;
      S_DONE:  if (out_ready_i) state_d = accept ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: valid comes from the state register only, so in_valid_i never reaches it.
  always_comb begin
    in_ready_o   = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready_i);
    accept       = in_valid_i && in_ready_o;
    out_valid_o  = (state_q == S_DONE);
    ciphertext_o = ct_q;
    round_o      = round_q;
  end

  // Datapath next values: load on accept, advance one round per RUN cycle.
  always_comb begin
    data_d  = data_q;
    ct_d    = ct_q;
    kwin_d  = kwin_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    if (accept) begin
      data_d  = plaintext_i ^ key_i[KEY_WIDTH-1 -: 128];
      kwin_d  = key_i;
      rcon_d  = 8'h01;
      round_d = 4'd1;
    end else if (state_q == S_RUN) begin
      data_d = round_res;
      kwin_d = kwin_nxt;
      if (use_rot) rcon_d = xtime(rcon_q);
      if (last_round) begin
        ct_d    = round_res;
        round_d = 4'd0;
      end else begin
        round_d = round_q + 4'd1;
      end
    end
  end

  // Datapath registers; reset discards any block in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      ct_q    <= '0;
      kwin_q  <= '0;
      rcon_q  <= '0;
      round_q <= '0;
    end else begin
      data_q  <= data_d;
      ct_q    <= ct_d;
      kwin_q  <= kwin_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
    end
  end

endmodule
